// File: rtl/approx_add_pkg.sv
// Shared types and defaults for the approximate-adder arbiter and its adder core.
package approx_add_pkg;

  localparam int DEFAULT_W        = 32;
  localparam int DEFAULT_LOA_BITS = 16;
  localparam int DEFAULT_NREQ     = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FULL = 1'b1
  } state_e;

endpackage

// File: rtl/approx_add_core.sv
// Combinational lower-part-OR approximate adder: the low LOA_BITS are ORed, with a carry
// generated from the top approximate bit into the exact upper part; exact=1 gives a true add.
module approx_add_core
  import approx_add_pkg::*;
#(
  parameter int W        = DEFAULT_W,
  parameter int LOA_BITS = DEFAULT_LOA_BITS
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         exact,
  output logic [W:0]   sum
);

  localparam int K = LOA_BITS;

  logic         c;
  logic [W-K:0] hi;
  logic [W:0]   approx_sum;
  logic [W:0]   exact_sum;

  always_comb begin
    c  = a[K-1] & b[K-1];
    hi = {1'b0, a[W-1:K]} + {1'b0, b[W-1:K]} + {{(W-K){1'b0}}, c};
    // Start from the OR of everything, then overwrite the bits that are not plain OR.
    approx_sum        = {1'b0, a | b};
    approx_sum[K-1]   = a[K-1] ^ b[K-1] ^ c;
    approx_sum[W:K]   = hi;
    exact_sum         = {1'b0, a} + {1'b0, b};
    sum               = exact ? exact_sum : approx_sum;
  end

endmodule

// File: rtl/approx_add_arbiter.sv
// Round-robin arbiter sharing one approximate adder among NREQ requesters, with a
// registered response. Optional EXACT_FALLBACK_EN adds per-request exact-add selection.
module approx_add_arbiter
  import approx_add_pkg::*;
#(
  parameter int W        = DEFAULT_W,
  parameter int LOA_BITS = DEFAULT_LOA_BITS,
  parameter int NREQ     = DEFAULT_NREQ,
  parameter int IDW      = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [W:0]        rsp_sum,
  output logic [IDW-1:0]    rsp_id
`ifdef EXACT_FALLBACK_EN
  ,
  input  logic [NREQ-1:0]   req_exact,
  output logic              rsp_exact
`endif
);

  // Handshakes: a request transfers on req_valid[i] & req_ready[i]; a response transfers
  // on rsp_valid & rsp_ready. rsp_* never change while rsp_valid & !rsp_ready.

  state_e         state;
  state_e         state_nxt;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] grant_idx;
  logic           grant_found;
  logic           slot_free;
  logic           accept;
  logic [W-1:0]   sel_a;
  logic [W-1:0]   sel_b;
  logic           sel_exact;
  logic [W:0]     core_sum;

  // Search NREQ candidates starting at rr_ptr; the first valid one wins.
  always_comb begin : grant_search
    int cand;
    cand        = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = (int'(rr_ptr) + i) % NREQ;
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(cand);
      end
    end
  end

  assign slot_free = !rsp_valid || rsp_ready;
  assign accept    = grant_found && slot_free && !rst;
  assign req_ready = accept ? (NREQ'(1) << grant_idx) : '0;

  assign sel_a = req_a[grant_idx*W +: W];
  assign sel_b = req_b[grant_idx*W +: W];

`ifdef EXACT_FALLBACK_EN
  assign sel_exact = req_exact[grant_idx];
`else
  assign sel_exact = 1'b0;
`endif

  approx_add_core #(
    .W        (W),
    .LOA_BITS (LOA_BITS)
  ) u_core (
    .a     (sel_a),
    .b     (sel_b),
    .exact (sel_exact),
    .sum   (core_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_FULL;
      ST_FULL: if (rsp_ready && !accept) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign rsp_valid = (state == ST_FULL);

  // Response register and pointer only move on an accepted request; a pop alone keeps the
  // stale payload, which is harmless because rsp_valid drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_sum <= '0;
      rsp_id  <= '0;
      rr_ptr  <= '0;
    end else if (accept) begin
      rsp_sum <= core_sum;
      rsp_id  <= grant_idx;
      rr_ptr  <= (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;
    end
  end

`ifdef EXACT_FALLBACK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_exact <= 1'b0;
    end else if (accept) begin
      rsp_exact <= sel_exact;
    end
  end
`endif

endmodule

// File: tb/tb_approx_add_arbiter.sv
// Scoreboard bench for approx_add_arbiter: the driver predicts grants and pushes expected
// responses; a separate monitor checks every presented response against the queue head.
module tb_approx_add_arbiter;

  localparam int W    = 32;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int EW   = 1 + IDW + W + 1;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [W:0]        rsp_sum;
  logic [IDW-1:0]    rsp_id;
`ifdef EXACT_FALLBACK_EN
  logic [NREQ-1:0]   req_exact;
  logic              rsp_exact;
`endif

  approx_add_arbiter #(
    .W        (W),
    .LOA_BITS (16),
    .NREQ     (NREQ),
    .IDW      (IDW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id)
`ifdef EXACT_FALLBACK_EN
    ,
    .req_exact (req_exact),
    .rsp_exact (rsp_exact)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog expired");
  end

  // scoreboard state
  logic [EW-1:0] exp_q[$];
  logic [W:0]    exp_sum [NREQ];
  logic          exp_ex  [NREQ];
  int            m_ptr;
  logic          m_valid;
  int            n_total;
  int            n_pass;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=0x%0h expected=0x%0h", name, got, want);
  endtask

  // driver tasks
  task automatic load(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W:0] s, input logic ex);
    req_a[idx*W +: W] = a;
    req_b[idx*W +: W] = b;
    exp_sum[idx]      = s;
    exp_ex[idx]       = ex;
`ifdef EXACT_FALLBACK_EN
    req_exact[idx]    = ex;
`endif
  endtask

  // One clock: check ready/valid against the reference model, update it, advance.
  task automatic step();
    logic [NREQ-1:0] want_ready;
    logic            free;
    int              g;
    @(negedge clk);
    want_ready = '0;
    g          = -1;
    free       = !m_valid || rsp_ready;
    if (!rst && free) begin
      for (int i = 0; i < NREQ; i++) begin
        if (g < 0 && req_valid[(m_ptr + i) % NREQ]) g = (m_ptr + i) % NREQ;
      end
    end
    if (g >= 0) want_ready[g] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(want_ready));
    check("rsp_valid", 64'(rsp_valid), 64'(m_valid));
    if (rst) begin
      m_valid = 1'b0;
      m_ptr   = 0;
      exp_q.delete();
    end else if (g >= 0) begin
      exp_q.push_back({exp_ex[g], IDW'(g), exp_sum[g]});
      m_ptr   = (g + 1) % NREQ;
      m_valid = 1'b1;
    end else if (rsp_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // monitor
  initial begin
    logic [EW-1:0] ent;
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL rsp_unexpected got id=%0d sum=0x%0h expected no response", rsp_id, rsp_sum);
        end else begin
          ent = exp_q[0];
          check("rsp_id", 64'(rsp_id), 64'(ent[W+IDW:W+1]));
          check("rsp_sum", 64'(rsp_sum), 64'(ent[W:0]));
`ifdef EXACT_FALLBACK_EN
          check("rsp_exact", 64'(rsp_exact), 64'(ent[EW-1]));
`endif
          if (rsp_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    n_total   = 0;
    n_pass    = 0;
    m_ptr     = 0;
    m_valid   = 1'b0;
    rst       = 1'b1;
    req_valid = '1;
    rsp_ready = 1'b1;
    req_a     = '0;
    req_b     = '0;
`ifdef EXACT_FALLBACK_EN
    req_exact = '0;
`endif
    for (int i = 0; i < NREQ; i++) begin
      exp_sum[i] = '0;
      exp_ex[i]  = 1'b0;
    end

    // reset: ready held low even with every requester valid
    step();
    step();
    rst = 1'b0;
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_sum", 64'(rsp_sum), 64'd0);
    check("rst_rsp_id", 64'(rsp_id), 64'd0);
`ifdef EXACT_FALLBACK_EN
    check("rst_rsp_exact", 64'(rsp_exact), 64'd0);
`endif
    req_valid = '0;

    // hand-computed vectors, K=16
    load(0, 32'h0000FFFF, 32'h00000001, 33'h0_0000FFFF, 1'b0);
    load(1, 32'h00008000, 32'h00008000, 33'h0_00018000, 1'b0);
    load(2, 32'hFFFFFFFF, 32'hFFFFFFFF, 33'h1_FFFFFFFF, 1'b0);
    load(3, 32'h12345678, 32'h0F0F00FF, 33'h0_214356FF, 1'b0);

    // all valid, full throughput: grants 0,1,2,3,0
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    repeat (5) step();
    req_valid = '0;
    repeat (2) step();

    // stall with requests pending: one accept, three held cycles, then pop+accept together
    load(0, 32'h00007FFF, 32'h00008000, 33'h0_0000FFFF, 1'b0);
    load(1, 32'hABCD1234, 32'h1111C0C0, 33'h0_BCDED2F4, 1'b0);
    load(2, 32'h80000000, 32'h80000000, 33'h1_00000000, 1'b0);
    load(3, 32'h0000C000, 32'h0000C000, 33'h0_0001C000, 1'b0);
    req_valid = 4'hF;
    rsp_ready = 1'b0;
    repeat (4) step();
    rsp_ready = 1'b1;
    repeat (2) step();
    req_valid = '0;
    repeat (2) step();

    // single requesters: pointer skips idle slots and wraps to 0
    req_valid = 4'b0100;
    step();
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    repeat (2) step();

    // reset with a response in flight: it is discarded, pointer returns to 0
    req_valid = 4'b0100;
    rsp_ready = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst       = 1'b0;
    req_valid = 4'b1010;
    rsp_ready = 1'b1;
    step();
    req_valid = '0;
    repeat (2) step();

`ifdef EXACT_FALLBACK_EN
    load(0, 32'h0000FFFF, 32'h00000001, 33'h0_00010000, 1'b1);
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    repeat (2) step();
`endif

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
